// File: rtl/prog_loader.sv
// Program loader: streams a byte image from a valid/ready source into the
// 16-byte RAM over the shared bus (MI/WE protocol), then checks a trailing checksum.
module prog_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] bus_out,
  output logic       bus_drive,
  output logic       MI,
  output logic       WE,
  output logic       cpu_halt,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [4:0] count
);

  localparam int DATA_W = 8;
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ADDR_ONE  = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_ADDR, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t              state;
  logic [ADDR_W:0]     addr;
  logic [DATA_W-1:0]   sum;
  logic [DATA_W-1:0]   data_q;

  function automatic logic [DATA_W-1:0] add_mod(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  function automatic logic [DATA_W-1:0] addr_on_bus(input logic [ADDR_W:0] a);
    return {{(DATA_W-ADDR_W){1'b0}}, a[ADDR_W-1:0]};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      addr      <= '0;
      sum       <= '0;
      data_q    <= '0;
      count     <= '0;
      in_ready  <= 1'b0;
      bus_out   <= '0;
      bus_drive <= 1'b0;
      MI        <= 1'b0;
      WE        <= 1'b0;
      cpu_halt  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      // Bus strobes are one-cycle pulses; every state that needs them re-asserts.
      bus_out   <= '0;
      bus_drive <= 1'b0;
      MI        <= 1'b0;
      WE        <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state    <= S_WAIT;
            addr     <= '0;
            sum      <= '0;
            count    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            cpu_halt <= 1'b1;
            busy     <= 1'b1;
            in_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (in_valid) begin
            data_q   <= in_data;
            in_ready <= 1'b0;
            if (addr < LAST_ADDR) begin
              state     <= S_ADDR;
              bus_drive <= 1'b1;
              MI        <= 1'b1;
              bus_out   <= addr_on_bus(addr);
            end else begin
              state <= S_CHECK;
            end
          end
        end
        S_ADDR: begin
          state     <= S_DATA;
          bus_drive <= 1'b1;
          WE        <= 1'b1;
          bus_out   <= data_q;
        end
        S_DATA: begin
          sum      <= add_mod(sum, data_q);
          addr     <= addr + ADDR_ONE;
          count    <= count + 5'd1;
          state    <= S_WAIT;
          in_ready <= 1'b1;
        end
        S_CHECK: begin
          busy <= 1'b0;
          if (add_mod(sum, data_q) == '0) begin
            state    <= S_DONE;
            done     <= 1'b1;
            cpu_halt <= 1'b0;
          end else begin
            state <= S_ERROR;
            err   <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writes a program image into the computer's 16-byte RAM over the shared 8-bit bus before the CPU runs.
- Holds the CPU halted while loading, and drives the bus using the memory's own MI (address latch) and WE (write) protocol.
- Accepts bytes from an external source over a valid/ready handshake and verifies a trailing two's-complement checksum.
- Releases the CPU only when the checksum passes.

Parameters:
DEPTH, 16, number of memory bytes loaded per image (addresses 0..DEPTH-1)
ADDR_W, 4, address width placed on bus[ADDR_W-1:0]; upper bus bits are zero

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst  in  1  reset, asynchronous, active-low
start  in  1  level sampled on clk; begins a load when the block is not busy
in_data  in  8  source byte
in_valid  in  1  in_data is valid
in_ready  out  1  loader accepts a byte this cycle
bus_out  out  8  value to drive on the system bus
bus_drive  out  1  loader owns the bus; the integrator's out_mux gives the loader priority while high
MI  out  1  memory address latch strobe (bus carries the address)
WE  out  1  memory write strobe (bus carries the data)
cpu_halt  out  1  ORed into HLT by the integrator
busy  out  1  load in progress
done  out  1  last load completed with a good checksum
err  out  1  last load failed its checksum
count  out  5  bytes written in the current or last load (0..DEPTH)

Behaviour:
- Reset (rst=0) forces state IDLE and clears everything asynchronously:
  - addr=0, sum=0, data_q=0, count=0.
  - All outputs 0, including bus_drive, MI, WE, in_ready, cpu_halt, done, err.
  - Reset asserted mid-load abandons the load immediately; the partially written memory is left as is.
- State machine states: IDLE, WAIT, ADDR, DATA, CHECK, DONE, ERROR.
- IDLE, DONE, ERROR:
  - If start=1, go to WAIT; clear addr, sum, count, done and err; set cpu_halt=1 and busy=1.
  - DONE holds done=1 and cpu_halt=0. ERROR holds err=1 and cpu_halt=1, so the CPU stays stopped.
- WAIT:
  - in_ready=1 (registered; high only in WAIT).
  - On the edge where in_valid=1 and in_ready=1, capture in_data into data_q.
  - Next state is ADDR if addr<DEPTH; otherwise the byte is the checksum and the next state is CHECK.
  - in_valid=0 means stay in WAIT indefinitely; there is no timeout.
- ADDR (exactly 1 cycle): bus_drive=1, bus_out={zeros, addr}, MI=1, then go to DATA.
- DATA (exactly 1 cycle):
  - bus_drive=1, bus_out=data_q, WE=1.
  - At the end of the cycle: sum<=sum+data_q mod 256, addr<=addr+1, count<=count+1, then go to WAIT.
- CHECK (1 cycle): if (sum+data_q) mod 256 == 0, go to DONE (cpu_halt<=0, busy<=0); otherwise go to ERROR (busy<=0).
- Strobes:
  - MI and WE are never high together.
  - MI and WE only assert while bus_drive=1; bus_drive is 0 in every other state.
- Throughput: 3 cycles per byte minimum (handshake, ADDR, DATA). A full 16-byte image plus checksum with in_valid held high takes 16*3+1+1 = 50 cycles from the first handshake to done.
- start while busy=1 is ignored.
- addr never wraps: after DEPTH writes, the next accepted byte is always the checksum, and no MI/WE is issued for it.
- Outputs are glitch-free registered values; no combinational path from in_valid to any output except through state.

Test Plan:
- Load bytes 0x00..0x0F plus checksum 0x88, in_valid always high -> 16 MI/WE pairs, with MI bus = 0x00..0x0F and the matching WE bus = byte; done=1, err=0, count=16, cpu_halt falls 50 cycles after the first handshake.
- Same image with checksum 0x00 -> err=1, done=0, cpu_halt stays 1, busy=0; a new start pulse restarts cleanly with count=0.
- Back-pressure: in_valid toggled 1,0,0,1 per byte -> no MI/WE while waiting; written contents identical to the first test; in_ready high only in WAIT.
- Timing check: handshake at edge k -> MI=1 with bus=addr in cycle k+1, WE=1 with bus=byte in cycle k+2, in_ready=1 again in cycle k+3.
- Pull rst low during the DATA cycle of address 5 -> all outputs 0 immediately (asynchronous); after release, state is IDLE and count=0.
- Pulse start during an active load at address 3 -> ignored; the load continues at address 3 with no duplicate MI.
